// File: rtl/pc_sequencer.sv
// Program counter and IDLE/RUN/HALT fetch sequencer; all outputs registered, 1-cycle control latency.
// Optional PC_REL_BRANCH_EN: taken branches add Target (two's complement) to ProgCtr instead of loading it.
module pc_sequencer #(
  parameter int PC_width  = 10,
  parameter int CNT_width = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Stall,
  input  logic                 BranchEn,
  input  logic [PC_width-1:0]  Target,
  input  logic                 Halt,
  output logic [PC_width-1:0]  ProgCtr,
  output logic                 Running,
  output logic                 Done,
  output logic [CNT_width-1:0] CycleCnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [PC_width-1:0]  PC_ONE  = {{(PC_width-1){1'b0}}, 1'b1};
  localparam logic [CNT_width-1:0] CNT_ONE = {{(CNT_width-1){1'b0}}, 1'b1};

  logic [1:0]          state;
  logic [PC_width-1:0] branch_pc;

`ifdef PC_REL_BRANCH_EN
  // Two's complement offset: a plain modular add gives the signed result.
  assign branch_pc = ProgCtr + Target;
`else
  assign branch_pc = Target;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      ProgCtr  <= '0;
      CycleCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state    <= RUN;
            ProgCtr  <= '0;
            CycleCnt <= '0;
          end
        end
        RUN: begin
          if (CycleCnt != {CNT_width{1'b1}})
            CycleCnt <= CycleCnt + CNT_ONE;
          // Halt > Stall > BranchEn > increment
          if (Halt)
            state <= HALT;
          else if (!Stall) begin
            if (BranchEn)
              ProgCtr <= branch_pc;
            else
              ProgCtr <= ProgCtr + PC_ONE;
          end
        end
        HALT: begin
          if (Start) begin
            state    <= RUN;
            ProgCtr  <= '0;
            CycleCnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Running = (state == RUN);
  assign Done    = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected observations are queued as stimulus is driven.
module tb_pc_sequencer;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0, Stall = 1'b0, BranchEn = 1'b0, Halt = 1'b0;
  logic [9:0]  Target = '0;
  logic [9:0]  ProgCtr;
  logic        Running, Done;
  logic [15:0] CycleCnt;

  typedef struct packed {
    logic [9:0]  pc;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    logic       st, sl, br, ht;
    logic [9:0] tg;
    obs_t       ex;
  } row_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  pc_sequencer #(.PC_width(10), .CNT_width(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .BranchEn(BranchEn),
    .Target(Target), .Halt(Halt), .ProgCtr(ProgCtr), .Running(Running),
    .Done(Done), .CycleCnt(CycleCnt)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic obs_t observe();
    return {ProgCtr, Running, Done, CycleCnt};
  endfunction

  function automatic obs_t mk(input int pc, input bit run, input bit done, input int cnt);
    obs_t r;
    r.pc = pc[9:0]; r.run = run; r.done = done; r.cnt = cnt[15:0];
    return r;
  endfunction

  function automatic row_t row(input bit st, sl, br, ht, input int tg,
                               input int pc, input bit run, done, input int cnt);
    row_t r;
    r.st = st; r.sl = sl; r.br = br; r.ht = ht; r.tg = tg[9:0];
    r.ex = mk(pc, run, done, cnt);
    return r;
  endfunction

  // Drive one cycle of inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic st, sl, br, ht, input logic [9:0] tg);
    Start = st; Stall = sl; BranchEn = br; Halt = ht; Target = tg;
    @(posedge Clk); #1;
    Start = 0; Stall = 0; BranchEn = 0; Halt = 0; Target = '0;
  endtask

  task automatic do_reset();
    Reset = 0;
    @(posedge Clk); #1;
    Reset = 1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    row_t rows[$];
    Reset = 0;
    #2;
    exp_q.push_back(mk(0, 0, 0, 0));
    e = exp_q.pop_front(); o = observe(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset_state: got pc=%0d run=%b done=%b cnt=%0d want pc=%0d run=%b done=%b cnt=%0d",
               o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
    end
    @(posedge Clk); #1;
    Reset = 1;
    rows.push_back(row(0, 0, 0, 0, 0,   0, 0, 0, 0));
    rows.push_back(row(0, 1, 1, 1, 99,  0, 0, 0, 0));
    foreach (rows[k]) begin
      exp_q.push_back(rows[k].ex);
      step(rows[k].st, rows[k].sl, rows[k].br, rows[k].ht, rows[k].tg);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL idle_hold[%0d]: got pc=%0d run=%b done=%b cnt=%0d want pc=%0d run=%b done=%b cnt=%0d",
                 k, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_count();
    obs_t e, o;
    row_t rows[$];
    do_reset();
    rows.push_back(row(1, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 1; i <= 5; i++)
      rows.push_back(row(i == 3, 0, 0, 0, 0, i, 1, 0, i));  // Start mid-run must be ignored
    foreach (rows[k]) begin
      exp_q.push_back(rows[k].ex);
      step(rows[k].st, rows[k].sl, rows[k].br, rows[k].ht, rows[k].tg);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL count[%0d]: got pc=%0d run=%b done=%b cnt=%0d want pc=%0d run=%b done=%b cnt=%0d",
                 k, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_branch();
    obs_t e, o;
    row_t rows[$];
    do_reset();
    step(1, 0, 0, 0, 0);
    repeat (7) step(0, 0, 0, 0, 0);
`ifdef PC_REL_BRANCH_EN
    rows.push_back(row(0, 0, 1, 0, 28,    35, 1, 0, 8));
    rows.push_back(row(0, 0, 0, 0, 0,     36, 1, 0, 9));
    rows.push_back(row(0, 0, 1, 0, 'h3FC, 32, 1, 0, 10));
`else
    rows.push_back(row(0, 0, 1, 0, 28,    28,   1, 0, 8));
    rows.push_back(row(0, 0, 0, 0, 0,     29,   1, 0, 9));
    rows.push_back(row(0, 0, 1, 0, 'h3FC, 1020, 1, 0, 10));
`endif
    foreach (rows[k]) begin
      exp_q.push_back(rows[k].ex);
      step(rows[k].st, rows[k].sl, rows[k].br, rows[k].ht, rows[k].tg);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL branch[%0d]: got pc=%0d run=%b done=%b cnt=%0d want pc=%0d run=%b done=%b cnt=%0d",
                 k, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_stall();
    obs_t e, o;
    row_t rows[$];
    do_reset();
    step(1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0);
    rows.push_back(row(0, 1, 1, 0, 51, 10, 1, 0, 11));
    rows.push_back(row(0, 0, 0, 0, 0,  11, 1, 0, 12));
    rows.push_back(row(0, 1, 0, 1, 0,  11, 0, 1, 13));
    rows.push_back(row(0, 1, 1, 1, 77, 11, 0, 1, 13));
    foreach (rows[k]) begin
      exp_q.push_back(rows[k].ex);
      step(rows[k].st, rows[k].sl, rows[k].br, rows[k].ht, rows[k].tg);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stall[%0d]: got pc=%0d run=%b done=%b cnt=%0d want pc=%0d run=%b done=%b cnt=%0d",
                 k, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    row_t rows[$];
    do_reset();
    step(1, 0, 0, 0, 0);
    // From PC 0 both branch modes land on 1022.
    rows.push_back(row(0, 0, 1, 0, 1022, 1022, 1, 0, 1));
    rows.push_back(row(0, 0, 0, 0, 0,    1023, 1, 0, 2));
    rows.push_back(row(0, 0, 0, 0, 0,    0,    1, 0, 3));
    rows.push_back(row(0, 0, 0, 0, 0,    1,    1, 0, 4));
    foreach (rows[k]) begin
      exp_q.push_back(rows[k].ex);
      step(rows[k].st, rows[k].sl, rows[k].br, rows[k].ht, rows[k].tg);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap[%0d]: got pc=%0d run=%b done=%b cnt=%0d want pc=%0d run=%b done=%b cnt=%0d",
                 k, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_halt_restart();
    obs_t e, o;
    row_t rows[$];
    do_reset();
    step(1, 0, 0, 0, 0);
    repeat (18) step(0, 0, 0, 0, 0);
`ifdef PC_REL_BRANCH_EN
    rows.push_back(row(0, 0, 1, 0, 127, 145, 1, 0, 19));
`else
    rows.push_back(row(0, 0, 1, 0, 145, 145, 1, 0, 19));
`endif
    rows.push_back(row(0, 0, 0, 1, 0,   145, 0, 1, 20));
    rows.push_back(row(0, 1, 1, 1, 300, 145, 0, 1, 20));
    rows.push_back(row(0, 0, 0, 0, 0,   145, 0, 1, 20));
    rows.push_back(row(1, 0, 0, 0, 0,   0,   1, 0, 0));
    rows.push_back(row(0, 0, 0, 0, 0,   1,   1, 0, 1));
    foreach (rows[k]) begin
      exp_q.push_back(rows[k].ex);
      step(rows[k].st, rows[k].sl, rows[k].br, rows[k].ht, rows[k].tg);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL halt[%0d]: got pc=%0d run=%b done=%b cnt=%0d want pc=%0d run=%b done=%b cnt=%0d",
                 k, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    row_t rows[$];
    do_reset();
    step(1, 0, 0, 0, 0);
    repeat (37) step(0, 0, 0, 0, 0);
    exp_q.push_back(mk(37, 1, 0, 37));
    exp_q.push_back(mk(0, 0, 0, 0));
    e = exp_q.pop_front(); o = observe(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL pre_reset: got pc=%0d run=%b done=%b cnt=%0d want pc=%0d run=%b done=%b cnt=%0d",
               o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
    end
    #3 Reset = 0;
    #1;
    e = exp_q.pop_front(); o = observe(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL async_reset: got pc=%0d run=%b done=%b cnt=%0d want pc=%0d run=%b done=%b cnt=%0d",
               o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
    end
    @(posedge Clk); #1;
    Reset = 1;
    rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row(0, 0, 1, 1, 9, 0, 0, 0, 0));
    rows.push_back(row(1, 0, 0, 0, 0, 0, 1, 0, 0));
    rows.push_back(row(0, 0, 0, 0, 0, 1, 1, 0, 1));
    foreach (rows[k]) begin
      exp_q.push_back(rows[k].ex);
      step(rows[k].st, rows[k].sl, rows[k].br, rows[k].ht, rows[k].tg);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL post_reset[%0d]: got pc=%0d run=%b done=%b cnt=%0d want pc=%0d run=%b done=%b cnt=%0d",
                 k, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_branch();
    test_stall();
    test_wrap();
    test_halt_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and fetch sequencer for the core.
- Sits directly downstream of the branch-target lookup table and consumes its PC_width Target output.
- Holds ProgCtr, which drives the instruction ROM address.
- Sequences the run lifecycle (idle, run, halt) and handles stalls and taken branches.
- Exports Done and a cycle count to the testbench/top level.

Parameters:
PC_width, 10, width of ProgCtr and Target
CNT_width, 16, width of the run-cycle counter

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  begin program execution at address 0
Stall  input  1  hold PC this cycle
BranchEn  input  1  taken branch/jump decoded this cycle
Target  input  PC_width  branch target from the lookup table
Halt  input  1  halt instruction decoded this cycle
ProgCtr  output  PC_width  current instruction address
Running  output  1  high while in RUN
Done  output  1  high while in HALT
CycleCnt  output  CNT_width  number of RUN cycles in current/last program

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State=IDLE, ProgCtr=0, Running=0, Done=0, CycleCnt=0.
  - Outputs change immediately on Reset going low, with no clock edge required.
  - Applies from any state, including mid-RUN.
- States: IDLE, RUN, HALT. All outputs are registered and decoded from state/registers only. No combinational input-to-output paths.
- IDLE:
  - ProgCtr held at 0.
  - Start=1 at a rising edge: go to RUN, CycleCnt=0, Done=0.
  - ProgCtr stays 0, so the first instruction fetched is address 0.
- RUN:
  - Running=1.
  - Each rising edge: CycleCnt += 1, saturating at all-ones (no wrap).
  - Next-PC priority: Halt > Stall > BranchEn > increment.
    - Halt=1: go to HALT; ProgCtr held; CycleCnt still increments for this cycle.
    - Stall=1 (no Halt): ProgCtr held. A simultaneous BranchEn is ignored; the upstream stage must hold it until the stall clears.
    - BranchEn=1: ProgCtr <= Target (absolute load), applied on the next edge.
    - Otherwise: ProgCtr <= ProgCtr + 1, modulo 2^PC_width (1023 -> 0 with defaults).
  - Start is ignored in RUN.
- HALT:
  - Done=1, Running=0.
  - ProgCtr and CycleCnt are frozen at their final values.
  - Stall, BranchEn and Halt are ignored.
  - Start=1: go to RUN; ProgCtr=0, CycleCnt=0, Done=0 on the same edge.
- Arithmetic and width rules:
  - Target is used at full PC_width; no truncation or extension in absolute mode.
  - All PC arithmetic wraps modulo 2^PC_width.
- Latency: every control input takes effect on ProgCtr at the next rising edge (1 cycle).

Optional Feature:
- Macro: PC_REL_BRANCH_EN
- Defined: a taken branch computes ProgCtr <= ProgCtr + Target.
  - Target is treated as two's complement PC_width (e.g. 0x3FC = -4).
  - The sum wraps modulo 2^PC_width.
  - Priority rules are unchanged.
- Undefined (default): absolute load, ProgCtr <= Target.

Test Plan:
1. Start pulse after reset, no other inputs for 5 cycles -> ProgCtr 0,1,2,3,4,5; Running=1; Done=0; CycleCnt=5.
2. ProgCtr=7, BranchEn=1, Target=28 -> ProgCtr=28 next edge, then 29. With PC_REL_BRANCH_EN: ProgCtr=8, Target=0x3FC -> ProgCtr=4.
3. ProgCtr=10, Stall=1 and BranchEn=1 with Target=51 -> ProgCtr stays 10. Next cycle with no inputs -> ProgCtr=11. Halt+Stall together -> HALT entered.
4. Force run to ProgCtr=1023 with no branch -> ProgCtr=0 next edge; Running stays 1.
5. Halt asserted at ProgCtr=145 on the 20th RUN cycle -> Done=1, Running=0, ProgCtr=145 held, CycleCnt=20. Then Start -> ProgCtr=0, Done=0, CycleCnt=0, Running=1.
6. Reset driven low between clock edges while ProgCtr=37 in RUN -> ProgCtr=0, Running=0, Done=0, CycleCnt=0 before the next edge. After release, state remains IDLE until Start.
